// File: rtl/life_engine.sv
// Game of Life engine: HEIGHT x WIDTH board, row loader, step/run evolution with programmable rules.
// Latency: a loaded row or a generation is visible one clock after the edge that accepts it.
// Backpressure: load_ready is always high; step/run are ignored while a frame is loading.
module life_engine #(
    parameter int HEIGHT = 18,
    parameter int WIDTH  = 18,
    parameter int WRAP   = 0,
    parameter int GEN_W  = 16,
    parameter int DIV_W  = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [0:WIDTH-1]              load_row,
    input  logic                          step,
    input  logic                          run,
    input  logic [DIV_W-1:0]              period,
    input  logic [8:0]                    rule_birth,
    input  logic [8:0]                    rule_survive,
    output logic [0:HEIGHT-1][0:WIDTH-1]  board,
    output logic [GEN_W-1:0]              generation,
    output logic                          loading,
    output logic                          extinct,
    output logic                          stable
);

    localparam int PW = $clog2(HEIGHT);
    localparam logic [PW-1:0] LAST_ROW = PW'(HEIGHT - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  ptr;
    logic [DIV_W-1:0]               div_cnt;
    logic [DIV_W-1:0]               div_term;
    logic                           gen_fire;
    logic [0:HEIGHT-1][0:WIDTH-1]   next_board;
    logic                           pad [0:HEIGHT+1][0:WIDTH+1];

    // Board surrounded by a one-cell halo: dead cells, or the opposite edge when wrapping.
    for (genvar pr = 0; pr < HEIGHT + 2; pr++) begin : g_pr
        for (genvar pc = 0; pc < WIDTH + 2; pc++) begin : g_pc
            localparam int SR = (pr == 0) ? HEIGHT - 1 : (pr == HEIGHT + 1) ? 0 : pr - 1;
            localparam int SC = (pc == 0) ? WIDTH - 1 : (pc == WIDTH + 1) ? 0 : pc - 1;
            localparam bit BORDER = (pr == 0) || (pr == HEIGHT + 1) || (pc == 0) || (pc == WIDTH + 1);
            if (BORDER && WRAP == 0) begin : g_dead
                assign pad[pr][pc] = 1'b0;
            end else begin : g_src
                assign pad[pr][pc] = board[SR][SC];
            end
        end
    end

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [3:0] n;
            assign n = {3'b000, pad[r][c]}     + {3'b000, pad[r][c+1]}   + {3'b000, pad[r][c+2]}
                     + {3'b000, pad[r+1][c]}                             + {3'b000, pad[r+1][c+2]}
                     + {3'b000, pad[r+2][c]}   + {3'b000, pad[r+2][c+1]} + {3'b000, pad[r+2][c+2]};
            assign next_board[r][c] = board[r][c] ? rule_survive[n] : rule_birth[n];
        end
    end

    assign div_term = (period == '0) ? '0 : period - DIV_W'(1);
    // A load handshake outranks run and step, so evolution needs an idle load port.
    assign gen_fire = (state_q == IDLE) && !clear && !load_valid &&
                      (run ? (div_cnt >= div_term) : step);
    assign extinct  = ~|board;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b1;
        loading    = (state_q == LOAD);
        if (load_valid) begin
            state_d = (ptr == LAST_ROW) ? IDLE : LOAD;
        end
        if (clear) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            board      <= '0;
            generation <= '0;
            stable     <= 1'b0;
            ptr        <= '0;
            div_cnt    <= '0;
        end else if (load_valid) begin
            board[ptr] <= load_row;
            div_cnt    <= '0;
            if (ptr == LAST_ROW) begin
                ptr        <= '0;
                generation <= '0;
                stable     <= 1'b0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end else begin
            if (gen_fire) begin
                board      <= next_board;
                generation <= generation + GEN_W'(1);
                stable     <= (next_board == board);
            end
            div_cnt <= (state_q == IDLE && run && !gen_fire) ? div_cnt + DIV_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench: 5x5 zero-border engine and 6x6 toroidal engine against hand-computed boards.
module tb_life_engine;

    localparam logic [8:0] CONWAY_B   = 9'b000001000;
    localparam logic [8:0] CONWAY_S   = 9'b000001100;
    localparam logic [8:0] HIGHLIFE_B = 9'b001001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic [23:0] period = '0;
    logic [8:0]  rule_birth = CONWAY_B;
    logic [8:0]  rule_survive = CONWAY_S;

    logic                 a_load_valid = 1'b0;
    logic                 a_load_ready;
    logic [0:4]           a_load_row = '0;
    logic                 a_step = 1'b0;
    logic [0:4][0:4]      a_board;
    logic [15:0]          a_generation;
    logic                 a_loading, a_extinct, a_stable;

    logic                 b_load_valid = 1'b0;
    logic                 b_load_ready;
    logic [0:5]           b_load_row = '0;
    logic                 b_step = 1'b0;
    logic                 b_run = 1'b0;
    logic [0:5][0:5]      b_board;
    logic [15:0]          b_generation;
    logic                 b_loading, b_extinct, b_stable;

    life_engine #(.HEIGHT(5), .WIDTH(5), .WRAP(0), .GEN_W(16), .DIV_W(24)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear),
        .load_valid(a_load_valid), .load_ready(a_load_ready), .load_row(a_load_row),
        .step(a_step), .run(run), .period(period),
        .rule_birth(rule_birth), .rule_survive(rule_survive),
        .board(a_board), .generation(a_generation), .loading(a_loading),
        .extinct(a_extinct), .stable(a_stable)
    );

    life_engine #(.HEIGHT(6), .WIDTH(6), .WRAP(1), .GEN_W(16), .DIV_W(24)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear),
        .load_valid(b_load_valid), .load_ready(b_load_ready), .load_row(b_load_row),
        .step(b_step), .run(b_run), .period(period),
        .rule_birth(rule_birth), .rule_survive(rule_survive),
        .board(b_board), .generation(b_generation), .loading(b_loading),
        .extinct(b_extinct), .stable(b_stable)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [0:4][0:4] img);
        for (int i = 0; i < 5; i++) begin
            a_load_valid = 1'b1;
            a_load_row   = img[i];
            tick();
        end
        a_load_valid = 1'b0;
    endtask

    task automatic load_b(input logic [0:5][0:5] img);
        for (int i = 0; i < 6; i++) begin
            b_load_valid = 1'b1;
            b_load_row   = img[i];
            tick();
        end
        b_load_valid = 1'b0;
    endtask

    localparam logic [0:4][0:4] BLINK_H = {5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000};
    localparam logic [0:4][0:4] BLINK_V = {5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    localparam logic [0:4][0:4] BLOCK   = {5'b00000, 5'b01100, 5'b01100, 5'b00000, 5'b00000};
    localparam logic [0:4][0:4] SIX_NB  = {5'b00000, 5'b01110, 5'b01010, 5'b01000, 5'b00000};
    localparam logic [0:5][0:5] GLIDER0 = {6'b010000, 6'b001000, 6'b111000, 6'b000000, 6'b000000, 6'b000000};
    localparam logic [0:5][0:5] GLIDER4 = {6'b000000, 6'b001000, 6'b000100, 6'b011100, 6'b000000, 6'b000000};

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        check("rst_board",   a_board, '0);
        check("rst_gen",     a_generation, 0);
        check("rst_ready",   a_load_ready, 1);
        check("rst_loading", a_loading, 0);
        check("rst_stable",  a_stable, 0);
        check("rst_extinct", a_extinct, 1);
        check("rst_b_board", b_board, '0);

        // Blinker load with a gap and a stray step while LOAD is active.
        for (int i = 0; i < 3; i++) begin
            a_load_valid = 1'b1;
            a_load_row   = BLINK_H[i];
            tick();
            if (i == 0) check("load_loading", a_loading, 1);
        end
        a_load_valid = 1'b0;
        a_step = 1'b1;
        tick();
        a_step = 1'b0;
        tick();
        check("gap_gen", a_generation, 0);
        for (int i = 3; i < 5; i++) begin
            a_load_valid = 1'b1;
            a_load_row   = BLINK_H[i];
            tick();
        end
        a_load_valid = 1'b0;
        check("load_done_loading", a_loading, 0);
        check("load_done_gen",     a_generation, 0);
        check("load_board",        a_board, BLINK_H);

        a_step = 1'b1; tick(); a_step = 1'b0;
        check("blink1_board",  a_board, BLINK_V);
        check("blink1_gen",    a_generation, 1);
        check("blink1_stable", a_stable, 0);
        a_step = 1'b1; tick(); a_step = 1'b0;
        check("blink2_board",  a_board, BLINK_H);
        check("blink2_gen",    a_generation, 2);
        check("blink2_stable", a_stable, 0);
        check("blink2_extinct", a_extinct, 0);

        // Free-running with period 3 on a still life.
        load_a(BLOCK);
        check("block_gen0", a_generation, 0);
        period = 24'd3;
        run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("run_gen_c%0d", i), a_generation, 64'(i / 3));
            if (i == 3) check("run_stable", a_stable, 1);
        end
        check("run_board", a_board, BLOCK);

        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_board",   a_board, '0);
        check("clr_gen",     a_generation, 0);
        check("clr_stable",  a_stable, 0);
        check("clr_extinct", a_extinct, 1);
        check("clr_loading", a_loading, 0);

        period = 24'd0;
        repeat (2) tick();
        check("p0_gen", a_generation, 2);
        run = 1'b0;

        // Reset partway through a load.
        for (int i = 0; i < 2; i++) begin
            a_load_valid = 1'b1;
            a_load_row   = 5'b11111;
            tick();
        end
        a_load_valid = 1'b0;
        check("ml_loading", a_loading, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mlrst_board",   a_board, '0);
        check("mlrst_loading", a_loading, 0);
        check("mlrst_gen",     a_generation, 0);
        check("mlrst_extinct", a_extinct, 1);
        check("mlrst_ready",   a_load_ready, 1);

        // Dead centre with six neighbours: born under HighLife, not under Conway.
        load_a(SIX_NB);
        rule_birth = HIGHLIFE_B;
        a_step = 1'b1; tick(); a_step = 1'b0;
        check("highlife_born", a_board[2][2], 1);
        load_a(SIX_NB);
        rule_birth = CONWAY_B;
        a_step = 1'b1; tick(); a_step = 1'b0;
        check("conway_dead", a_board[2][2], 0);

        // Toroidal glider: step held high for 24 cycles returns to the start.
        load_b(GLIDER0);
        check("glider_load", b_board, GLIDER0);
        b_step = 1'b1;
        repeat (4) tick();
        check("glider4_board", b_board, GLIDER4);
        repeat (20) tick();
        b_step = 1'b0;
        check("glider24_board",   b_board, GLIDER0);
        check("glider24_gen",     b_generation, 24);
        check("glider24_stable",  b_stable, 0);
        check("glider24_extinct", b_extinct, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Game of Life evolution engine, successor to the fixed 18x18 switch-loaded board. Holds an HEIGHT x WIDTH cell array, accepts an initial pattern one row per valid/ready handshake, and advances generations on single-step pulses or at a programmable free-running rate. Supports a zero-border or toroidal edge mode and runtime birth/survive rule masks. Reports generation count, extinction and stability. Sits between the switch/row-input logic and the display driver.

## Interface
- HEIGHT, 18: number of rows, >= 3.
- WIDTH, 18: number of columns, >= 3.
- WRAP, 0: 0 = cells outside the array read as dead; 1 = toroidal (row/column indices modulo HEIGHT/WIDTH).
- GEN_W, 16: generation counter width.
- DIV_W, 24: run-period width.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- clear  in  1  synchronous board/counter clear.
- load_valid  in  1  load_row carries a valid row.
- load_ready  out  1  engine accepts a row this cycle.
- load_row  in  [0:WIDTH-1]  row data; bit 0 = column 0.
- step  in  1  one-cycle pulse: advance one generation.
- run  in  1  level: free-running evolution.
- period  in  DIV_W  cycles per generation while run is high; 0 treated as 1.
- rule_birth  in  9  bit n set: a dead cell with n live neighbours becomes alive.
- rule_survive  in  9  bit n set: a live cell with n live neighbours stays alive.
- board  out  [0:HEIGHT-1][0:WIDTH-1]  current generation, registered.
- generation  out  GEN_W  generations since the last completed load or clear.
- loading  out  1  high in LOAD state.
- extinct  out  1  board is all zero.
- stable  out  1  the most recent generation equalled its predecessor.

## Operation
- States: IDLE, LOAD.
- IDLE: load_ready = 1. load_valid enters LOAD and writes row 0; row pointer becomes 1.
- LOAD: load_ready = 1. Each handshake writes board[ptr] <= load_row and increments ptr. Accepting row HEIGHT-1 returns to IDLE, resets ptr to 0, and clears generation and stable. step and run are ignored in LOAD.
- Evolution happens only in IDLE, for the whole array in one clock. For each cell, n = its live neighbour count, 0..8 in 4 bits. next = alive ? rule_survive[n] : rule_birth[n].
- WRAP=0: out-of-range neighbours count as 0. WRAP=1: corner neighbours wrap diagonally.
- step in IDLE with run low: exactly one generation.
- run high in IDLE: the divider counts 0..max(period,1)-1. A generation occurs in the cycle where the divider equals the terminal value; the divider then returns to 0. The divider holds at 0 while run is low or in LOAD. step is ignored while run is high.
- Per generation: generation increments modulo 2^GEN_W. stable <= (next == board).
- extinct is the combinational NOR of board.
- Priority: reset > clear > load handshake > run > step.
- clear: board, generation, stable, divider and ptr go to 0; state returns to IDLE. A partially loaded frame is discarded.
- Rule inputs are sampled in the generation cycle. Changing them takes effect on the next generation.
- Conway: rule_birth = 9'b000001000, rule_survive = 9'b000001100.

## Timing
- Reset values: board all 0, generation 0, state IDLE, load_ready 1, loading 0, stable 0, extinct 1, ptr 0, divider 0.
- Load: row accepted at edge t; visible on board at t+1. After the last row, loading falls and generation = 0 at t+1.
- step sampled high at edge t: new board and generation visible at t+1. A step held high for k cycles gives k generations.
- run: with run first sampled high at edge t and period P, the first update is visible after edge t+P-1. Subsequent updates follow every P cycles.
- period changed mid-run: applies when the divider next reaches its terminal value. If the divider already exceeds the new terminal value, a generation occurs on the next cycle.
- Reset or clear mid-run or mid-load: takes effect at that edge; no generation occurs in that cycle.

## Test plan
- Conway, WRAP=0, 5x5: load a horizontal blinker at row 2, columns 1-3. Step -> vertical at column 2, rows 1-3, generation=1. Step -> horizontal again, generation=2. stable=0 throughout.
- Conway, WRAP=1, 6x6: load a glider. 24 steps -> same glider shape, offset by (6,6) mod 6, i.e. identical to the load; stable=0, extinct=0.
- Load handshake with load_valid gaps, plus a step pulse during LOAD. Required: rows land in order, no generation occurs, generation=0 after the last row.
- run=1, period=3, on a 2x2 block (still life): updates after cycles 3, 6 and 9; stable=1 after the first update; generation=3 after 9 cycles.
- HighLife (rule_birth bits 3 and 6): a dead cell with 6 neighbours is born. Under Conway rules the same cell stays dead.
- Reset mid-load after 2 rows, then clear mid-run: every output returns to its reset value on the next cycle; generation=0 and extinct=1.
